// File: rtl/key_loader_if.sv
// Board-side signal bundle of the key loader: raw key and switches in, load
// strobe with captured values and status out.
interface key_loader_if;
  logic       key_n;
  logic [3:0] sw_in;
  logic [1:0] sw_cnt;
  logic       load_en;
  logic [3:0] in;
  logic [1:0] cnt;
  logic       busy;
  logic [7:0] load_count;

  // Drives the board inputs and observes the loader (stimulus side).
  modport master (
    output key_n, sw_in, sw_cnt,
    input  load_en, in, cnt, busy, load_count
  );

  // The loader itself.
  modport slave (
    input  key_n, sw_in, sw_cnt,
    output load_en, in, cnt, busy, load_count
  );
endinterface

// File: rtl/key_loader.sv
// Debounces the KEY pushbutton and, once per accepted press, captures the
// switches and issues a one-cycle load strobe to the lab FSM.
module key_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic        clk_50m,
  input logic        rst,
  key_loader_if.slave bus
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StReleaseDb} state_e;

  state_e          state_q;
  logic [CntW-1:0] db_cnt_q;
  logic            sync1_q, sync2_q;
  logic            load_en_q;
  logic [3:0]      in_q;
  logic [1:0]      cnt_q;
  logic            busy_q;
  logic [7:0]      load_count_q;
  logic            pressed;

  assign pressed = ~sync2_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      // Synchronizer resets to "released" so a held key needs a full new press.
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= StIdle;
      db_cnt_q     <= '0;
      load_en_q    <= 1'b0;
      in_q         <= 4'h0;
      cnt_q        <= 2'b00;
      busy_q       <= 1'b0;
      load_count_q <= 8'h00;
    end else begin
      sync1_q   <= bus.key_n;
      sync2_q   <= sync1_q;
      load_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pressed) begin
            state_q  <= StPressDb;
            db_cnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        StPressDb: begin
          if (!pressed) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (db_cnt_q == CntLast) begin
            state_q      <= StHeld;
            load_en_q    <= 1'b1;
            in_q         <= bus.sw_in;
            cnt_q        <= bus.sw_cnt;
            load_count_q <= load_count_q + 8'd1;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        StHeld: begin
          if (!pressed) begin
            state_q  <= StReleaseDb;
            db_cnt_q <= '0;
          end
        end
        StReleaseDb: begin
          // A bounce back to pressed returns to HELD without a new load.
          if (pressed) begin
            state_q <= StHeld;
          end else if (db_cnt_q == CntLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_en    = load_en_q;
  assign bus.in         = in_q;
  assign bus.cnt        = cnt_q;
  assign bus.busy       = busy_q;
  assign bus.load_count = load_count_q;

endmodule

// File: tb/tb_key_loader.sv
// Bench for key_loader: directed scenarios plus random key/switch activity,
// checked every cycle against a streak-counting reference model.
module tb_key_loader;

  localparam int unsigned N = 4;

  logic clk_50m = 1'b0;
  logic rst;

  key_loader_if bus ();

  key_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .bus     (bus)
  );

  always #10 clk_50m = ~clk_50m;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: key seen through two delay stages, then a load is due when
  // the key has been pressed for N+1 consecutive cycles starting from idle, and
  // idle is regained after N+1 consecutive released cycles.
  logic       m_s1, m_s2;
  bit         m_idle;
  int         hi_run, lo_run;
  bit         m_load;
  logic [3:0] m_in;
  logic [1:0] m_cnt;
  logic [7:0] m_lc;
  logic [3:0] cur_sw;
  logic [1:0] cur_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1   = 1'b1;
    m_s2   = 1'b1;
    m_idle = 1'b1;
    hi_run = 0;
    lo_run = 0;
    m_load = 1'b0;
    m_in   = 4'h0;
    m_cnt  = 2'b00;
    m_lc   = 8'h00;
  endtask

  task automatic check_outputs();
    check("load_en", bus.load_en, m_load);
    check("in", bus.in, m_in);
    check("cnt", bus.cnt, m_cnt);
    check("busy", bus.busy, (!m_idle || hi_run > 0));
    check("load_count", bus.load_count, m_lc);
  endtask

  task automatic step(input logic k);
    logic p;
    bus.key_n  = k;
    bus.sw_in  = cur_sw;
    bus.sw_cnt = cur_cnt;
    @(posedge clk_50m);
    if (rst) begin
      model_reset();
    end else begin
      p      = ~m_s2;
      m_s2   = m_s1;
      m_s1   = k;
      m_load = 1'b0;
      if (p) begin
        hi_run++;
        lo_run = 0;
      end else begin
        lo_run++;
        hi_run = 0;
      end
      if (m_idle && hi_run == N + 1) begin
        m_idle = 1'b0;
        m_load = 1'b1;
        m_in   = cur_sw;
        m_cnt  = cur_cnt;
        m_lc   = m_lc + 8'd1;
      end else if (!m_idle && lo_run == N + 1) begin
        m_idle = 1'b1;
      end
    end
    #1;
    check_outputs();
    if (bus.load_en === 1'b1) pulses++;
  endtask

  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  // Reset asserted between edges so its asynchronous effect is visible at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_load_en", bus.load_en, 1'b0);
    check("rst_async_busy", bus.busy, 1'b0);
    check("rst_async_in", bus.in, 4'h0);
    check("rst_async_count", bus.load_count, 8'h00);
    step(bus.key_n);
    rst = 1'b0;
  endtask

  initial begin
    int run;
    logic k;
    rst        = 1'b1;
    bus.key_n  = 1'b1;
    bus.sw_in  = 4'h0;
    bus.sw_cnt = 2'b00;
    cur_sw     = 4'h0;
    cur_cnt    = 2'b00;
    model_reset();
    #5;
    check("reset_load_en", bus.load_en, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_in", bus.in, 4'h0);
    check("reset_cnt", bus.cnt, 2'b00);
    check("reset_load_count", bus.load_count, 8'h00);
    step(1'b1);
    rst = 1'b0;
    hold(1'b1, 3);

    // Clean press: strobe on the 7th cycle after the key is first sampled low.
    cur_sw  = 4'hA;
    cur_cnt = 2'b10;
    pulses  = 0;
    hold(1'b0, 6);
    check("clean_no_early_pulse", pulses, 0);
    step(1'b0);
    check("clean_strobe_cycle", bus.load_en, 1'b1);
    hold(1'b0, 13);
    check("clean_pulses", pulses, 1);
    check("clean_in", bus.in, 4'hA);
    check("clean_cnt", bus.cnt, 2'b10);
    check("clean_load_count", bus.load_count, 8'd1);
    hold(1'b1, 10);

    // Glitch rejection.
    do_reset();
    hold(1'b1, 2);
    pulses = 0;
    hold(1'b0, 3);
    hold(1'b1, 10);
    check("glitch_pulses", pulses, 0);
    check("glitch_in", bus.in, 4'h0);
    check("glitch_cnt", bus.cnt, 2'b00);
    check("glitch_busy", bus.busy, 1'b0);

    // Release bounce.
    do_reset();
    hold(1'b1, 2);
    hold(1'b0, 12);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    hold(1'b1, 6);
    check("bounce_busy_before", bus.busy, 1'b1);
    step(1'b1);
    check("bounce_busy_after", bus.busy, 1'b0);
    check("bounce_pulses", pulses, 0);
    hold(1'b1, 3);

    // Switch isolation.
    do_reset();
    cur_sw = 4'h3;
    hold(1'b1, 2);
    hold(1'b0, 10);
    cur_sw = 4'h5;
    hold(1'b0, 5);
    hold(1'b1, 4);
    check("iso_in_held", bus.in, 4'h3);
    hold(1'b1, 6);
    hold(1'b0, 10);
    check("iso_in_second", bus.in, 4'h5);
    check("iso_load_count", bus.load_count, 8'd2);
    hold(1'b1, 10);

    // Mid-debounce reset with the key still held.
    do_reset();
    hold(1'b1, 2);
    hold(1'b0, 4);
    check("mid_busy_in_press_db", bus.busy, 1'b1);
    do_reset();
    pulses = 0;
    hold(1'b0, 6);
    check("mid_no_early_pulse", pulses, 0);
    step(1'b0);
    check("mid_strobe_cycle", bus.load_en, 1'b1);
    hold(1'b0, 5);
    check("mid_pulses", pulses, 1);
    hold(1'b1, 10);

    // Counter wrap.
    do_reset();
    hold(1'b1, 2);
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      cur_sw  = 4'($urandom);
      cur_cnt = 2'($urandom);
      hold(1'b0, 7);
      if (i == 254) check("wrap_255", bus.load_count, 8'd255);
      if (i == 255) check("wrap_0", bus.load_count, 8'd0);
      hold(1'b1, 7);
    end
    check("wrap_pulses", pulses, 256);

    // Random key runs, switch noise and occasional resets.
    k   = 1'b1;
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        k   = ~k;
        run = $urandom_range(1, 12);
      end
      run--;
      cur_sw  = 4'($urandom);
      cur_cnt = 2'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
